hazard_controller: RTL
======================

# hazard_controller

Pipeline sequencer that decides, every cycle, whether the five-stage MIPS pipeline advances, stalls, bubbles or flushes. It detects load-use hazards between ID and EX, flushes wrong-path fetches after a taken branch/jump, and freezes the whole pipeline while data memory is busy. It drives the PC write enable, the IF/ID write/flush controls and the enable of the control-signal mux feeding ID/EX (0 = insert bubble, all control signals zero).

## Interface
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
- FLUSH_CYCLES, 1, fetch slots squashed per taken branch/jump (1..7)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- id_ex_mem_read  input  1  instruction in EX is a load
- id_ex_rt  input  5  destination register of the load in EX
- if_id_rs  input  5  rs of instruction in ID
- if_id_rt  input  5  rt of instruction in ID
- if_id_uses_rt  input  1  ID instruction reads rt (R-type, branch, store)
- branch_taken  input  1  resolved taken branch/J/JR/JALR this cycle
- mem_busy  input  1  data memory not ready; pipeline must freeze
- pc_write  output  1  PC loads next value
- if_id_write  output  1  IF/ID register loads
- if_id_flush  output  1  IF/ID loads a NOP
- control_enable  output  1  1 = pass decoded control, 0 = bubble into ID/EX
- pipe_hold  output  1  ID/EX, EX/MEM, MEM/WB hold their contents
- state_dbg  output  2  current state encoding

## Operation
- States: RUN, LU_STALL, FLUSH, MEM_WAIT; 3-bit down-counter cnt; saved return state ret_state and saved counter ret_cnt.
- Load-use hazard (lu): id_ex_mem_read && id_ex_rt != 0 && (id_ex_rt == if_id_rs || (if_use_rt && id_ex_rt == if_id_rt)).
- Priority in every state: mem_busy > branch_taken > lu.
- RUN outputs: pc_write=1, if_id_write=1, if_id_flush=0, control_enable=1, pipe_hold=0.
- RUN + lu: pc_write=0, if_id_write=0, control_enable=0 this cycle; if LOAD_STALL_CYCLES>1 go LU_STALL with cnt=LOAD_STALL_CYCLES-2, else stay RUN.
- RUN + branch_taken: pc_write=1, if_id_flush=1, control_enable=0 this cycle; if FLUSH_CYCLES>1 go FLUSH with cnt=FLUSH_CYCLES-2.
- LU_STALL: same outputs as lu cycle; cnt==0 -> RUN, else decrement. lu is not re-evaluated here.
- FLUSH: pc_write=1, if_id_flush=1, control_enable=0; cnt==0 -> RUN, else decrement.
- branch_taken in LU_STALL: abandon stall, behave as RUN+branch_taken (older instruction wins).
- branch_taken in FLUSH: restart flush count from FLUSH_CYCLES-2 (stays or returns per count).
- mem_busy in any state: pc_write=0, if_id_write=0, if_id_flush=0, control_enable=1, pipe_hold=1; on entry from RUN/LU_STALL/FLUSH save ret_state and ret_cnt, go MEM_WAIT. Counter frozen.
- MEM_WAIT: hold outputs while mem_busy; when mem_busy=0, that cycle is evaluated as ret_state with ret_cnt (lu/branch_taken evaluated normally if ret_state=RUN).

## Timing
- Outputs are combinational from state, cnt and inputs (Mealy); zero-cycle response to lu, branch_taken, mem_busy.
- State/cnt update on rising clk.
- During reset: state=RUN, cnt=0, ret_state=RUN, ret_cnt=0; all outputs forced 0 (pc_write=0, if_id_write=0, if_id_flush=0, control_enable=0, pipe_hold=0, state_dbg=0).
- Reset asserted mid-stall/flush/wait: sequence aborted immediately, no resume after release.
- First cycle after reset release: RUN outputs.
- Load-use total bubbles = LOAD_STALL_CYCLES; flush slots = FLUSH_CYCLES, plus any MEM_WAIT cycles, which insert no bubbles.

## Configuration
- HAZARD_PERF_COUNTERS_EN defined: adds outputs stall_count, flush_count, wait_count (16 bits each), incremented once per cycle spent in lu/LU_STALL, branch/FLUSH, mem_busy respectively; saturate at 16'hFFFF; cleared by reset.
- Undefined: these ports and registers do not exist; behaviour otherwise identical.

## Structure
- hazard_pkg: state encoding (RUN=0, LU_STALL=1, FLUSH=2, MEM_WAIT=3), register-index width 5, counter width 3, perf counter width 16.
- Sub-module load_use_detector: purely combinational lu compare; FSM, counters and output decode in hazard_controller.

## Test plan
- Load to $t0 in EX (id_ex_rt=8), ID reads rs=8, defaults -> one cycle pc_write=0, if_id_write=0, control_enable=0, then RUN outputs.
- Same with id_ex_rt=0 -> no stall, RUN outputs throughout.
- LOAD_STALL_CYCLES=3, lu pulse -> exactly 3 stall cycles; branch_taken in 2nd -> stall ends, if_id_flush=1 that cycle.
- FLUSH_CYCLES=2, branch_taken one cycle -> if_id_flush=1, control_enable=0 for 2 cycles, pc_write=1 throughout.
- FLUSH_CYCLES=3, mem_busy high 4 cycles after first flush cycle -> 4 cycles pipe_hold=1, then 2 remaining flush cycles.
- Reset asserted mid-FLUSH -> all outputs 0 immediately; after release RUN outputs, no further flush.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and widths for the pipeline hazard controller.
// Output bundle order: {pc_write, if_id_write, if_id_flush, control_enable, pipe_hold}.
package hazard_pkg;

  localparam int unsigned RegIdxW = 5;
  localparam int unsigned CntW    = 3;
  localparam int unsigned PerfW   = 16;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLuStall = 2'd1,
    StFlush   = 2'd2,
    StMemWait = 2'd3
  } state_e;

  localparam logic [4:0] OutRun   = 5'b11010;
  localparam logic [4:0] OutStall = 5'b00000;
  localparam logic [4:0] OutFlush = 5'b11100;
  localparam logic [4:0] OutWait  = 5'b00011;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard compare between the load in EX and the instruction in ID.
module load_use_detector
  import hazard_pkg::*;
(
  input  logic               id_ex_mem_read,
  input  logic [RegIdxW-1:0] id_ex_rt,
  input  logic [RegIdxW-1:0] if_id_rs,
  input  logic [RegIdxW-1:0] if_id_rt,
  input  logic               if_id_uses_rt,
  output logic               lu
);

  // $zero never carries a real dependency.
  always_comb begin
    lu = id_ex_mem_read && (id_ex_rt != '0) &&
         ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
  end

endmodule

// File: rtl/hazard_controller.sv
// Five-stage pipeline sequencer: load-use stalls, branch flushes and memory-wait freezes.
// Define HAZARD_PERF_COUNTERS_EN to add saturating stall/flush/wait cycle counters.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES      = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_ex_mem_read,
  input  logic [RegIdxW-1:0] id_ex_rt,
  input  logic [RegIdxW-1:0] if_id_rs,
  input  logic [RegIdxW-1:0] if_id_rt,
  input  logic               if_id_uses_rt,
  input  logic               branch_taken,
  input  logic               mem_busy,
  output logic               pc_write,
  output logic               if_id_write,
  output logic               if_id_flush,
  output logic               control_enable,
  output logic               pipe_hold,
  output logic [1:0]         state_dbg
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [PerfW-1:0]   stall_count,
  output logic [PerfW-1:0]   flush_count,
  output logic [PerfW-1:0]   wait_count
`endif
);

  localparam bit LuMulti = LOAD_STALL_CYCLES > 1;
  localparam bit FlMulti = FLUSH_CYCLES > 1;
  localparam logic [CntW-1:0] LuInit = CntW'(LuMulti ? LOAD_STALL_CYCLES - 2 : 0);
  localparam logic [CntW-1:0] FlInit = CntW'(FlMulti ? FLUSH_CYCLES - 2 : 0);

  state_e          state_q, state_d, ret_state_q, ret_state_d, eff_state;
  logic [CntW-1:0] cnt_q, cnt_d, ret_cnt_q, ret_cnt_d, eff_cnt;
  logic [4:0]      out_d;
  logic            lu;

  load_use_detector u_lu (
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rt       (id_ex_rt),
    .if_id_rs       (if_id_rs),
    .if_id_rt       (if_id_rt),
    .if_id_uses_rt  (if_id_uses_rt),
    .lu             (lu)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ret_state_d = ret_state_q;
    ret_cnt_d   = ret_cnt_q;
    out_d       = OutRun;
    // The cycle mem_busy drops is evaluated as the interrupted state.
    eff_state   = (state_q == StMemWait) ? ret_state_q : state_q;
    eff_cnt     = (state_q == StMemWait) ? ret_cnt_q : cnt_q;

    if (mem_busy) begin
      out_d = OutWait;
      if (state_q != StMemWait) begin
        ret_state_d = state_q;
        ret_cnt_d   = cnt_q;
        state_d     = StMemWait;
      end
    end else if (branch_taken) begin
      // Abandons a load-use stall and restarts a flush in progress.
      out_d   = OutFlush;
      state_d = FlMulti ? StFlush : StRun;
      cnt_d   = FlInit;
    end else begin
      unique case (eff_state)
        StRun: begin
          state_d = StRun;
          cnt_d   = '0;
          if (lu) begin
            out_d   = OutStall;
            state_d = LuMulti ? StLuStall : StRun;
            cnt_d   = LuInit;
          end
        end
        StLuStall: begin
          out_d   = OutStall;
          state_d = (eff_cnt == '0) ? StRun : StLuStall;
          cnt_d   = (eff_cnt == '0) ? '0 : eff_cnt - CntW'(1);
        end
        StFlush: begin
          out_d   = OutFlush;
          state_d = (eff_cnt == '0) ? StRun : StFlush;
          cnt_d   = (eff_cnt == '0) ? '0 : eff_cnt - CntW'(1);
        end
        default: begin
          state_d = StRun;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      ret_state_q <= StRun;
      ret_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ret_state_q <= ret_state_d;
      ret_cnt_q   <= ret_cnt_d;
    end
  end

  always_comb begin
    {pc_write, if_id_write, if_id_flush, control_enable, pipe_hold} = reset ? 5'b00000 : out_d;
    state_dbg = reset ? 2'b00 : state_q;
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [PerfW-1:0] stall_q, stall_d, flush_q, flush_d, wait_q, wait_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    wait_d  = wait_q;
    if (!mem_busy && (out_d == OutStall) && (stall_q != '1)) stall_d = stall_q + PerfW'(1);
    if (!mem_busy && (out_d == OutFlush) && (flush_q != '1)) flush_d = flush_q + PerfW'(1);
    if (mem_busy && (wait_q != '1)) wait_d = wait_q + PerfW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
      wait_q  <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
      wait_q  <= wait_d;
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;
  assign wait_count  = wait_q;
`endif

endmodule
